irq_ctrl: RTL and testbench

//  Interrupt controller downstream of the timer and other peripherals. Collects NUM_SRC

---
 rtl/irq_ctrl_pkg.sv | 15 +
 rtl/irq_ctrl_if.sv | 27 ++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_ctrl.sv | 144 ++++++++++++++
 tb/tb_irq_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared definitions for the interrupt controller.
//   Register offsets (decoded on addr_i[3:0]) and the FSM state encoding.
package irq_ctrl_pkg;

    localparam logic [3:0] ADDR_ENABLE  = 4'h0;
    localparam logic [3:0] ADDR_PENDING = 4'h4;
    localparam logic [3:0] ADDR_CLAIM   = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: register bus plus core request/ack handshake of irq_ctrl.
//   addr_i, data_i, wr_en_i : register access from the bus master
//   data_o                  : combinational read data
//   irq_o, irq_id_o         : registered request and source ID to the core
//   irq_ack_i               : core acceptance of the current request
// master = bus/core side, slave = irq_ctrl.
interface irq_ctrl_if #(
    parameter int unsigned ID_W = 4
);
    logic [31:0]     addr_i;
    logic [31:0]     data_i;
    logic            wr_en_i;
    logic [31:0]     data_o;
    logic            irq_o;
    logic [ID_W-1:0] irq_id_o;
    logic            irq_ack_i;

    modport master (
        output addr_i, data_i, wr_en_i, irq_ack_i,
        input  data_o, irq_o, irq_id_o
    );

    modport slave (
        input  addr_i, data_i, wr_en_i, irq_ack_i,
        output data_o, irq_o, irq_id_o
    );
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index priority encoder.
//   vec_i : NUM_SRC request bits
//   id_o  : index+1 of the lowest set bit, 0 when no bit is set
module irq_prio_enc #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = $clog2(NUM_SRC) + 1
) (
    input  logic [NUM_SRC-1:0] vec_i,
    output logic [ID_W-1:0]    id_o
);

    logic found;

    always_comb begin
        id_o  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (vec_i[i] && !found) begin
                id_o  = ID_W'(i + 1);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: level-interrupt collector with edge-latched pending bits,
// per-source enable, lowest-index priority and a claim/complete handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   src_i      : NUM_SRC level interrupt lines, synchronous to clk
//   bus        : register port (ENABLE 0x0, PENDING 0x4 W1C, CLAIM 0x8)
//                and registered irq_o/irq_id_o with irq_ack_i from the core
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = $clog2(NUM_SRC) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    irq_ctrl_if.slave          bus
);

    irq_state_e         state;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] ack_mask;
    logic [ID_W-1:0]    claimed_id;
    logic [ID_W-1:0]    best_id;
    logic               irq_q;
    logic [ID_W-1:0]    irq_id_q;
    logic [3:0]         offs;
    logic               wr_enable;
    logic               wr_pending;
    logic               wr_claim;
    logic               ack_fire;
    logic               complete;
    logic [31:0]        rdata;
    logic               unused_bits;

    assign offs        = bus.addr_i[3:0];
    assign unused_bits = ^{bus.addr_i[31:4], bus.data_i};

    assign wr_enable  = bus.wr_en_i && (offs == ADDR_ENABLE);
    assign wr_pending = bus.wr_en_i && (offs == ADDR_PENDING);
    assign wr_claim   = bus.wr_en_i && (offs == ADDR_CLAIM);

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .vec_i (pending & enable),
        .id_o  (best_id)
    );

    // An ack is only taken while a request is still valid; if the request
    // vanished in the same cycle the FSM drops back to IDLE instead.
    assign ack_fire = (state == ST_REQ) && bus.irq_ack_i && (best_id != '0);
    assign complete = (state == ST_SERVICE) && wr_claim &&
                      (bus.data_i[ID_W-1:0] == claimed_id);

    always_comb begin
        rise     = src_i & ~src_q;
        w1c_mask = wr_pending ? bus.data_i[NUM_SRC-1:0] : '0;
        ack_mask = '0;
        if (ack_fire) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                ack_mask[i] = (irq_id_q == ID_W'(i + 1));
            end
        end
        // New edges override both W1C and ack clears.
        pending_nxt = (pending & ~w1c_mask & ~ack_mask) | rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            enable     <= '0;
            pending    <= '0;
            src_q      <= '0;
            claimed_id <= '0;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            src_q   <= src_i;
            pending <= pending_nxt;
            if (wr_enable) begin
                enable <= bus.data_i[NUM_SRC-1:0];
            end
            case (state)
                ST_IDLE: begin
                    if (best_id != '0) begin
                        state    <= ST_REQ;
                        irq_q    <= 1'b1;
                        irq_id_q <= best_id;
                    end
                end
                ST_REQ: begin
                    if (best_id == '0) begin
                        state    <= ST_IDLE;
                        irq_q    <= 1'b0;
                        irq_id_q <= '0;
                    end else if (ack_fire) begin
                        state      <= ST_SERVICE;
                        claimed_id <= irq_id_q;
                        irq_q      <= 1'b0;
                        irq_id_q   <= '0;
                    end else begin
                        irq_id_q <= best_id;
                    end
                end
                ST_SERVICE: begin
                    if (complete) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    irq_q    <= 1'b0;
                    irq_id_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (rst_n) begin
            case (offs)
                ADDR_ENABLE:  rdata = 32'(enable);
                ADDR_PENDING: rdata = 32'(pending);
                ADDR_CLAIM: begin
                    rdata     = 32'(claimed_id);
                    rdata[31] = (state == ST_SERVICE);
                end
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.data_o   = rdata;
    assign bus.irq_o    = irq_q;
    assign bus.irq_id_o = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed test of irq_ctrl with NUM_SRC=8 (ID_W=4).
module tb_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] src_i;

    int unsigned n_checks;
    int unsigned n_pass;

    irq_ctrl_if #(.ID_W(4)) bus ();

    irq_ctrl #(
        .NUM_SRC (8),
        .ID_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .src_i (src_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
        bus.addr_i  = addr;
        bus.data_i  = data;
        bus.wr_en_i = 1'b1;
        tick();
        bus.wr_en_i = 1'b0;
    endtask

    task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
        bus.addr_i = addr;
        #1;
        data = bus.data_o;
    endtask

    task automatic check_irq(input string tag, input logic exp_irq, input logic [3:0] exp_id);
        check({tag, "_irq"}, 32'(bus.irq_o), 32'(exp_irq));
        check({tag, "_id"}, 32'(bus.irq_id_o), 32'(exp_id));
    endtask

    logic [31:0] rd;

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        src_i        = '0;
        bus.addr_i   = '0;
        bus.data_i   = '0;
        bus.wr_en_i  = 1'b0;
        bus.irq_ack_i = 1'b0;
        repeat (3) tick();

        // Reset state
        check_irq("rst", 1'b0, 4'd0);
        rst_n = 1'b1;
        reg_read(32'h0, rd); check("rst_enable", rd, 32'h0);
        reg_read(32'h4, rd); check("rst_pending", rd, 32'h0);
        reg_read(32'h8, rd); check("rst_claim", rd, 32'h0);

        // 1: single source, two-clock latency
        reg_write(32'h0, 32'h01);
        src_i = 8'h01;
        tick();
        src_i = 8'h00;
        check_irq("t1_edge", 1'b0, 4'd0);
        reg_read(32'h4, rd); check("t1_pending", rd, 32'h01);
        tick();
        check_irq("t1_req", 1'b1, 4'd1);

        // ack outside REQ would be ignored; here we are in REQ
        // 2: ack, then wrong and right complete
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        check_irq("t2_ack", 1'b0, 4'd0);
        reg_read(32'h4, rd); check("t2_pending", rd, 32'h0);
        reg_read(32'h8, rd); check("t2_claim", rd, 32'h8000_0001);
        reg_write(32'h8, 32'h2);
        reg_read(32'h8, rd); check("t2_bad_complete", rd, 32'h8000_0001);
        reg_write(32'h8, 32'h1);
        reg_read(32'h8, rd); check("t2_in_service", 32'(rd[31]), 32'h0);
        tick();
        check_irq("t2_idle", 1'b0, 4'd0);

        // 3: preemption before ack; bits above NUM_SRC ignored
        reg_write(32'h0, 32'hFFFF_FFFF);
        reg_read(32'h0, rd); check("t3_enable_mask", rd, 32'hFF);
        reg_read(32'h100, rd); check("t3_upper_addr", rd, 32'hFF);
        reg_read(32'hC, rd); check("t3_unmapped", rd, 32'h0);
        src_i = 8'h20;
        tick();
        src_i = 8'h00;
        tick();
        check_irq("t3_req6", 1'b1, 4'd6);
        src_i = 8'h04;
        tick();
        src_i = 8'h00;
        check_irq("t3_still6", 1'b1, 4'd6);
        tick();
        check_irq("t3_preempt3", 1'b1, 4'd3);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        reg_read(32'h8, rd); check("t3_claim", rd, 32'h8000_0003);
        reg_read(32'h4, rd); check("t3_pending", rd, 32'h20);
        check_irq("t3_service", 1'b0, 4'd0);
        reg_write(32'h8, 32'h3);
        tick();
        check_irq("t3_next6", 1'b1, 4'd6);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        reg_write(32'h8, 32'h6);
        tick();
        check_irq("t3_done", 1'b0, 4'd0);

        // 4: pending while masked, then unmask
        reg_write(32'h0, 32'h0);
        src_i = 8'h01;
        tick();
        src_i = 8'h00;
        reg_read(32'h4, rd); check("t4_pending", rd, 32'h01);
        tick();
        tick();
        check_irq("t4_masked", 1'b0, 4'd0);
        reg_write(32'h0, 32'h01);
        check_irq("t4_unmask_1clk", 1'b0, 4'd0);
        tick();
        check_irq("t4_unmask_2clk", 1'b1, 4'd1);

        // 5: W1C collides with new edge -> set wins; then W1C drops request
        src_i = 8'h01;
        reg_write(32'h4, 32'h01);
        reg_read(32'h4, rd); check("t5_set_wins", rd, 32'h01);
        check_irq("t5_req", 1'b1, 4'd1);
        reg_write(32'h4, 32'h01);
        reg_read(32'h4, rd); check("t5_w1c", rd, 32'h0);
        tick();
        check_irq("t5_drop", 1'b0, 4'd0);
        src_i = 8'h00;

        // 6: reset during SERVICE with src 3 held high
        reg_write(32'h0, 32'hFF);
        src_i = 8'h08;
        tick();
        tick();
        check_irq("t6_req", 1'b1, 4'd4);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        reg_read(32'h8, rd); check("t6_claim", rd, 32'h8000_0004);
        rst_n = 1'b0;
        reg_read(32'h0, rd); check("t6_rd_in_reset", rd, 32'h0);
        tick();
        tick();
        check_irq("t6_reset", 1'b0, 4'd0);
        rst_n = 1'b1;
        reg_read(32'h0, rd); check("t6_enable", rd, 32'h0);
        reg_read(32'h8, rd); check("t6_claim_clr", rd, 32'h0);
        reg_read(32'h4, rd); check("t6_pending_clr", rd, 32'h0);
        tick();
        reg_read(32'h4, rd); check("t6_pending_edge", rd, 32'h08);
        check_irq("t6_no_req", 1'b0, 4'd0);
        reg_write(32'h0, 32'hFF);
        tick();
        check_irq("t6_new_req", 1'b1, 4'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
